mem_boot_loader: RTL and testbench

Serial boot loader and memory-port arbiter between the 8-bit MIPS core and its code/data memory. After reset it holds the core in reset, receives a length-prefixed byte image over a bit-serial link, and writes the image into memory from address 0x00 upward. It then releases the core and passes the core's memory write port straight through to memory.

---
 rtl/mem_boot_loader.sv | 76 +++++++
 tb/tb_mem_boot_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: serial boot loader and memory write-port arbiter for the 8-bit core
// Ports: clk, reset (sync, active-high); boot_load selects load or skip in IDLE;
//        ser_valid/ser_bit carry the length-prefixed image, MSB first;
//        cpu_memwrite/cpu_adr/cpu_writedata are the core's write port;
//        mem_memwrite/mem_adr/mem_writedata drive memory; cpu_reset holds the core;
//        loading is high while an image is being received.
module mem_boot_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_load,
    input  logic       ser_valid,
    input  logic       ser_bit,
    input  logic       cpu_memwrite,
    input  logic [7:0] cpu_adr,
    input  logic [7:0] cpu_writedata,
    output logic       mem_memwrite,
    output logic [7:0] mem_adr,
    output logic [7:0] mem_writedata,
    output logic       cpu_reset,
    output logic       loading
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, RUN} state_t;
    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic [8:0] remaining;
    logic [7:0] ptr;
    logic [7:0] dbuf;
    logic       shift_en;
    logic       byte_done;
    logic [7:0] byte_in;
    assign shift_en  = (state == LEN) || (state == DATA) || (state == WRITE);
    assign byte_done = shift_en && ser_valid && (bitcnt == 3'd7);
    assign byte_in   = {shreg[6:0], ser_bit};
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= 8'd0;
            bitcnt    <= 3'd0;
            remaining <= 9'd0;
            ptr       <= 8'd0;
            dbuf      <= 8'd0;
        end else begin
            if (shift_en && ser_valid) begin
                shreg  <= byte_in;
                bitcnt <= bitcnt + 3'd1;
            end
            case (state)
                IDLE: state <= boot_load ? LEN : RUN;
                LEN: if (byte_done) begin
                    // a length byte of 0x00 encodes 256
                    remaining <= {byte_in == 8'd0, byte_in};
                    state     <= DATA;
                end
                DATA: if (byte_done) begin
                    dbuf  <= byte_in;
                    state <= WRITE;
                end
                WRITE: begin
                    ptr       <= ptr + 8'd1;
                    remaining <= remaining - 9'd1;
                    state     <= (remaining == 9'd1) ? RUN : DATA;
                end
                RUN: state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        mem_memwrite  = (state == RUN) ? cpu_memwrite  : (state == WRITE);
        mem_adr       = (state == RUN) ? cpu_adr       : ptr;
        mem_writedata = (state == RUN) ? cpu_writedata : dbuf;
        cpu_reset     = (state != RUN);
        loading       = shift_en;
    end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: directed bench with a byte-level reference model checked every cycle
module tb_mem_boot_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       boot_load = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_bit = 1'b0;
    logic       cpu_memwrite = 1'b0;
    logic [7:0] cpu_adr = 8'd0;
    logic [7:0] cpu_writedata = 8'd0;
    logic       mem_memwrite;
    logic [7:0] mem_adr;
    logic [7:0] mem_writedata;
    logic       cpu_reset;
    logic       loading;

    mem_boot_loader dut (
        .clk(clk), .reset(reset), .boot_load(boot_load),
        .ser_valid(ser_valid), .ser_bit(ser_bit),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .mem_memwrite(mem_memwrite), .mem_adr(mem_adr), .mem_writedata(mem_writedata),
        .cpu_reset(cpu_reset), .loading(loading)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_n = 0;
    logic [15:0] wq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counts accepted strobes and completed writes per byte,
    // phase 0 = just out of reset, 1 = receiving image, 2 = core running.
    int         m_phase = 0;
    int         m_bits = 0;
    int         m_len = 0;
    int         m_done = 0;
    logic [7:0] m_acc = 8'd0;
    logic [7:0] m_data = 8'd0;
    logic       m_wr = 1'b0;
    logic       m_live = 1'b0;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (reset) begin
            m_phase = 0; m_bits = 0; m_len = 0; m_done = 0;
            m_acc = 8'd0; m_data = 8'd0; m_wr = 1'b0;
        end else if (m_phase == 0) begin
            m_phase = boot_load ? 1 : 2;
        end else if (m_phase == 1) begin
            if (m_wr) begin
                m_wr = 1'b0;
                m_done++;
                if (m_done == m_len) m_phase = 2;
            end
            if (ser_valid && m_phase == 1) begin
                m_acc = {m_acc[6:0], ser_bit};
                m_bits++;
                if (m_bits % 8 == 0) begin
                    if (m_bits == 8) m_len = (m_acc == 8'd0) ? 256 : int'(m_acc);
                    else begin
                        m_data = m_acc;
                        m_wr = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [18:0] exp_v;
        if (m_live) begin
            exp_v = (m_phase == 2) ? {1'b0, 1'b0, cpu_memwrite, cpu_adr, cpu_writedata}
                                   : {1'b1, m_phase == 1, m_wr, m_done[7:0], m_data};
            chk("cycle_outputs", {cpu_reset, loading, mem_memwrite, mem_adr, mem_writedata}, exp_v);
            if (mem_memwrite && cpu_reset) wq.push_back({mem_adr, mem_writedata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        for (int i = 7; i >= 0; i--) begin
            ser_valid = 1'b1;
            ser_bit = b[i];
            tick();
            ser_valid = 1'b0;
            ser_bit = 1'b0;
            if (gapped) repeat ((i == 0) ? 0 : (strobe_n % 6)) tick();
            strobe_n++;
        end
    endtask

    task automatic start_load();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        boot_load = 1'b1;
        tick();
        wq.delete();
    endtask

    task automatic wait_run();
        int n = 0;
        while (cpu_reset && n < 8) begin
            tick();
            n++;
        end
        chk("run_reached", cpu_reset, 1'b0);
    endtask

    task automatic load3(input bit gapped);
        start_load();
        cpu_memwrite = 1'b1; cpu_adr = 8'hEE; cpu_writedata = 8'h77;
        send_byte(8'h03, gapped);
        send_byte(8'h11, gapped);
        send_byte(8'h22, gapped);
        send_byte(8'h33, gapped);
        chk("last_write_cycle", {cpu_reset, mem_memwrite, mem_adr, mem_writedata}, {1'b1, 1'b1, 8'h02, 8'h33});
        tick();
        chk("cpu_released", {cpu_reset, mem_memwrite, mem_adr}, {1'b0, 1'b1, 8'hEE});
        chk("write_count", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("write0", wq[0], 16'h0011);
            chk("write1", wq[1], 16'h0122);
            chk("write2", wq[2], 16'h0233);
        end
        cpu_memwrite = 1'b0;
    endtask

    initial begin
        int bad;
        repeat (2) tick();
        chk("reset_outputs", {cpu_reset, loading, mem_memwrite, mem_adr, mem_writedata}, 19'h40000);
        // skip loading
        reset = 1'b0;
        boot_load = 1'b0;
        tick();
        cpu_memwrite = 1'b1; cpu_adr = 8'h20; cpu_writedata = 8'h5A;
        #1;
        chk("skip_run", {cpu_reset, loading}, 2'b00);
        chk("skip_passthru", {mem_memwrite, mem_adr, mem_writedata}, {1'b1, 8'h20, 8'h5A});
        cpu_memwrite = 1'b0;
        tick();
        // 3-byte image back-to-back, then gapped
        load3(1'b0);
        load3(1'b1);
        // 256-byte image
        start_load();
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 256; k++) send_byte(8'(k), 1'b0);
        wait_run();
        chk("len256_count", wq.size(), 256);
        bad = 0;
        foreach (wq[k]) if (wq[k] != {8'(k), 8'(k)}) bad++;
        chk("len256_adr_eq_data", bad, 0);
        if (wq.size() > 0) chk("len256_last", wq[$], 16'hFFFF);
        // reset in the middle of a load
        start_load();
        send_byte(8'h03, 1'b0);
        send_byte(8'h10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ser_valid = 1'b1; ser_bit = 1'b1; tick();
        end
        ser_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midload_reset", {cpu_reset, loading, mem_memwrite, mem_adr, mem_writedata}, 19'h40000);
        reset = 1'b0;
        boot_load = 1'b1;
        tick();
        wq.delete();
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        wait_run();
        chk("reload_count", wq.size(), 1);
        if (wq.size() == 1) chk("reload_write", wq[0], 16'h00AA);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
